// File: rtl/fp_link_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package     : fp_link_pkg                                             |
// | Description : Shared constants and types for the host side of the     |
// |               byte-serial FP multiplier link.                         |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
package fp_link_pkg;

   // Link framing: two operands out, one product back
   localparam int OP_BYTES = 8;
   localparam int TX_BYTES = 16;
   localparam int RX_BYTES = 8;

   // IEEE-754 double field widths
   localparam int SIGN_W = 1;
   localparam int EXP_W  = 11;
   localparam int FRAC_W = 52;

   typedef struct packed {
      logic [SIGN_W-1:0] sign;
      logic [EXP_W-1:0]  expn;
      logic [FRAC_W-1:0] frac;
   } fp64_t;

   // Host FSM encoding
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_DRST = 3'd1;
   localparam state_t ST_SEND = 3'd2;
   localparam state_t ST_WAIT = 3'd3;
   localparam state_t ST_RECV = 3'd4;
   localparam state_t ST_RESP = 3'd5;

endpackage : fp_link_pkg
`default_nettype wire

// File: rtl/fp_link_deser.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : fp_link_deser                                           |
// | Description : 8-byte MSB-first capture shift register with byte       |
// |               count, synchronous clear and a done flag.               |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module fp_link_deser
   import fp_link_pkg::*;
(
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    clear,
   input  logic                    shift_en,
   input  logic [7:0]              data_in,
   output logic [RX_BYTES*8-1:0]   data,
   output logic                    done
);

   logic [3:0] r_count;

   // Shift each captured byte in at the LSB end so byte 0 ends up at the MSB
   always_ff @(posedge CLK) begin
      if (RESET || clear) begin
         data    <= '0;
         r_count <= '0;
      end else if (shift_en) begin
         data    <= {data[RX_BYTES*8-9:0], data_in};
         r_count <= r_count + 4'd1;
      end
   end

   assign done = (r_count == 4'(RX_BYTES));

endmodule : fp_link_deser
`default_nettype wire

// File: rtl/fp_mult_host.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : fp_mult_host                                            |
// | Description : Host-side initiator for the byte-serial FP multiplier.  |
// |               Resets the multiplier, streams A then B MSB first,      |
// |               collects the 8-byte product and returns it, with a      |
// |               timeout error if the multiplier never answers.          |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module fp_mult_host
   import fp_link_pkg::*;
#(
   parameter int RST_CYCLES = 2,
   parameter int WAIT_MAX   = 64
)(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] op_a,
   input  logic [63:0] op_b,
   output logic        resp_valid,
   output logic [63:0] result,
   output logic        resp_err,
   output logic        dut_reset,
   output logic        dut_enable,
   output logic [7:0]  dut_data_in,
   input  logic        dut_ready,
   input  logic [7:0]  dut_data_out
);

   localparam int                  c_RCNT_W    = $clog2(RST_CYCLES + 1);
   localparam int                  c_WCNT_W    = $clog2(WAIT_MAX + 1);
   localparam logic [c_RCNT_W-1:0] c_RST_LAST  = c_RCNT_W'(RST_CYCLES - 1);
   localparam logic [c_WCNT_W-1:0] c_WAIT_LAST = c_WCNT_W'(WAIT_MAX - 1);
   localparam logic [3:0]          c_TX_LAST   = 4'(TX_BYTES - 1);

   state_t                  r_state;
   state_t                  w_next;
   logic [TX_BYTES*8-1:0]   r_tx;
   logic [3:0]              r_byte_cnt;
   logic [c_RCNT_W-1:0]     r_rst_cnt;
   logic [c_WCNT_W-1:0]     r_wait_cnt;
   logic [RX_BYTES*8-1:0]   w_rx_data;
   logic                    w_rx_done;
   logic                    w_accept;
   logic                    w_collecting;
   logic                    w_capture;
   logic                    w_expire;

   assign w_accept     = req_valid && req_ready;
   assign w_collecting = (r_state == ST_WAIT) || (r_state == ST_RECV);
   // A byte is taken whenever the multiplier presents one and the frame is not yet full
   assign w_capture    = w_collecting && dut_ready && !w_rx_done;
   // Timeout only fires on a cycle with no byte available; a byte arriving on the
   // last allowed cycle still counts
   assign w_expire     = w_collecting && !dut_ready && !w_rx_done &&
                         (r_wait_cnt == c_WAIT_LAST);

   fp_link_deser u_deser (
      .CLK      (CLK),
      .RESET    (RESET),
      .clear    (r_state == ST_SEND),
      .shift_en (w_capture),
      .data_in  (dut_data_out),
      .data     (w_rx_data),
      .done     (w_rx_done)
   );

   // Next-state selection for the transaction sequence
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)                    w_next = ST_DRST;
         ST_DRST: if (r_rst_cnt == c_RST_LAST)     w_next = ST_SEND;
         ST_SEND: if (r_byte_cnt == c_TX_LAST)     w_next = ST_WAIT;
         ST_WAIT: begin
            if (dut_ready)                         w_next = ST_RECV;
            else if (w_expire)                     w_next = ST_RESP;
         end
         ST_RECV: if (w_rx_done || w_expire)       w_next = ST_RESP;
         ST_RESP:                                  w_next = ST_IDLE;
         default:                                  w_next = ST_IDLE;
      endcase
   end

   // State, counters and all outputs; outputs are registered from the next state
   // so they line up with the state they belong to
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state     <= ST_IDLE;
         r_tx        <= '0;
         r_byte_cnt  <= '0;
         r_rst_cnt   <= '0;
         r_wait_cnt  <= '0;
         req_ready   <= 1'b0;
         resp_valid  <= 1'b0;
         result      <= '0;
         resp_err    <= 1'b0;
         dut_reset   <= 1'b1;
         dut_enable  <= 1'b0;
         dut_data_in <= '0;
      end else begin
         r_state    <= w_next;
         req_ready  <= (w_next == ST_IDLE);
         dut_reset  <= (w_next == ST_DRST);
         dut_enable <= (w_next == ST_SEND);
         resp_valid <= (w_next == ST_RESP);

         r_rst_cnt  <= (r_state == ST_DRST) ? r_rst_cnt + 1'b1 : '0;

         // Byte counter wraps 15 -> 0 on the last SEND cycle
         if (r_state == ST_SEND)
            r_byte_cnt <= r_byte_cnt + 4'd1;

         // Cleared outside WAIT/RECV so it starts from zero on WAIT entry
         if (!w_collecting)
            r_wait_cnt <= '0;
         else if (r_wait_cnt != c_WAIT_LAST)
            r_wait_cnt <= r_wait_cnt + 1'b1;

         if (w_accept)
            r_tx <= {op_a, op_b};
         else if (w_next == ST_SEND)
            r_tx <= {r_tx[TX_BYTES*8-9:0], 8'h00};

         dut_data_in <= (w_next == ST_SEND) ? r_tx[TX_BYTES*8-1 -: 8] : 8'h00;

         if (w_next == ST_RESP) begin
            result   <= w_expire ? 64'h0 : w_rx_data;
            resp_err <= w_expire;
         end
      end
   end

endmodule : fp_mult_host
`default_nettype wire
